// File: rtl/regfile_csr.sv
// Architectural state for the in-order pipeline: 32xXLEN GPR file with x0 hardwired to zero,
// plus machine-mode CSRs with free-running mcycle/minstret counters. Reads are combinational.
module regfile_csr #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            wreg_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] rd_wdata_i,
  input  logic [11:0]     csr_raddr_i,
  output logic [XLEN-1:0] csr_data_o,
  input  logic            csr_wreg_i,
  input  logic [11:0]     csr_waddr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'('h1800);
  localparam logic [XLEN-1:0] BIT0_CLEAR  = ~XLEN'(1);

  logic [XLEN-1:0] r_gpr [32];
  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mcycle;
  logic [XLEN-1:0] r_minstret;

  logic w_wr_mstatus;
  logic w_wr_mtvec;
  logic w_wr_mscratch;
  logic w_wr_mepc;
  logic w_wr_mcause;
  logic w_wr_mcycle;
  logic w_wr_minstret;

  assign w_wr_mstatus  = csr_wreg_i && (csr_waddr_i == ADDR_MSTATUS);
  assign w_wr_mtvec    = csr_wreg_i && (csr_waddr_i == ADDR_MTVEC);
  assign w_wr_mscratch = csr_wreg_i && (csr_waddr_i == ADDR_MSCRATCH);
  assign w_wr_mepc     = csr_wreg_i && (csr_waddr_i == ADDR_MEPC);
  assign w_wr_mcause   = csr_wreg_i && (csr_waddr_i == ADDR_MCAUSE);
  assign w_wr_mcycle   = csr_wreg_i && (csr_waddr_i == ADDR_MCYCLE);
  assign w_wr_minstret = csr_wreg_i && (csr_waddr_i == ADDR_MINSTRET);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
      r_mstatus  <= MSTATUS_RST;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (wreg_i && (rd_addr_i != 5'd0)) r_gpr[rd_addr_i] <= rd_wdata_i;
      if (w_wr_mstatus)  r_mstatus  <= csr_wdata_i;
      if (w_wr_mtvec)    r_mtvec    <= csr_wdata_i;
      if (w_wr_mscratch) r_mscratch <= csr_wdata_i;
      // A software write to a counter replaces the increment for that cycle
      r_mcycle <= w_wr_mcycle ? csr_wdata_i : r_mcycle + XLEN'(1);
      if (w_wr_minstret)  r_minstret <= csr_wdata_i;
      else if (retire_i)  r_minstret <= r_minstret + XLEN'(1);
      // The trap owns mepc/mcause; a colliding software write to them is dropped
      if (trap_i) begin
        r_mepc   <= trap_pc_i & BIT0_CLEAR;
        r_mcause <= trap_cause_i;
      end else begin
        if (w_wr_mepc)   r_mepc   <= csr_wdata_i & BIT0_CLEAR;
        if (w_wr_mcause) r_mcause <= csr_wdata_i;
      end
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : r_gpr[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : r_gpr[rs2_addr_i];

  // mhartid and unimplemented addresses fall through to zero
  always_comb begin
    csr_data_o = '0;
    case (csr_raddr_i)
      ADDR_MSTATUS:  csr_data_o = r_mstatus;
      ADDR_MTVEC:    csr_data_o = r_mtvec;
      ADDR_MSCRATCH: csr_data_o = r_mscratch;
      ADDR_MEPC:     csr_data_o = r_mepc;
      ADDR_MCAUSE:   csr_data_o = r_mcause;
      ADDR_MCYCLE:   csr_data_o = r_mcycle;
      ADDR_MINSTRET: csr_data_o = r_minstret;
      default:       csr_data_o = '0;
    endcase
  end

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;

endmodule

// File: tb/tb_regfile_csr.sv
// Scoreboarded bench for regfile_csr: directed scenarios then random traffic, checked against
// an array/associative-array model of the architectural state.
module tb_regfile_csr;

  localparam int W = 64;

  logic          clk;
  logic          rst;
  logic [4:0]    rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [W-1:0]  rs1_data_o, rs2_data_o, rd_wdata_i;
  logic          wreg_i, csr_wreg_i, retire_i, trap_i;
  logic [11:0]   csr_raddr_i, csr_waddr_i;
  logic [W-1:0]  csr_data_o, csr_wdata_i, trap_pc_i, trap_cause_i, mtvec_o, mepc_o;

  regfile_csr #(.XLEN(W)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .wreg_i(wreg_i), .rd_addr_i(rd_addr_i), .rd_wdata_i(rd_wdata_i),
    .csr_raddr_i(csr_raddr_i), .csr_data_o(csr_data_o),
    .csr_wreg_i(csr_wreg_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .retire_i(retire_i), .trap_i(trap_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [W-1:0] m_gpr [32];
  logic [W-1:0] m_csr [int];

  function automatic void model_reset();
    foreach (m_gpr[i]) m_gpr[i] = '0;
    m_csr.delete();
    m_csr['h300] = 64'h1800;
    m_csr['h305] = '0;
    m_csr['h340] = '0;
    m_csr['h341] = '0;
    m_csr['h342] = '0;
    m_csr['hB00] = '0;
    m_csr['hB02] = '0;
  endfunction

  function automatic logic [W-1:0] model_csr_rd(int a);
    if (m_csr.exists(a)) return m_csr[a];
    return '0;
  endfunction

  // Applies one clock edge of architectural rules using the inputs presented this cycle
  function automatic void model_edge();
    int a;
    if (rst) begin
      model_reset();
      return;
    end
    if (wreg_i && rd_addr_i != 0) m_gpr[rd_addr_i] = rd_wdata_i;
    m_csr['hB00] = m_csr['hB00] + 1;
    if (retire_i) m_csr['hB02] = m_csr['hB02] + 1;
    a = int'(csr_waddr_i);
    if (csr_wreg_i && m_csr.exists(a) && !(trap_i && (a == 'h341 || a == 'h342)))
      m_csr[a] = (a == 'h341) ? (csr_wdata_i & ~64'd1) : csr_wdata_i;
    if (trap_i) begin
      m_csr['h341] = trap_pc_i & ~64'd1;
      m_csr['h342] = trap_cause_i;
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int           cyc;
    int           port;
    logic [W-1:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic string port_name(int p);
    case (p)
      0: return "rs1_data";
      1: return "rs2_data";
      2: return "csr_data";
      3: return "mtvec";
      default: return "mepc";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      case (e.port)
        0: act = rs1_data_o;
        1: act = rs2_data_o;
        2: act = csr_data_o;
        3: act = mtvec_o;
        default: act = mepc_o;
      endcase
      n_total++;
      if (e.cyc != cyc)
        $display("FAIL stale_%s cyc=%0d queued_for=%0d", port_name(e.port), cyc, e.cyc);
      else if (act !== e.exp)
        $display("FAIL %s cyc=%0d rs1=%0d rs2=%0d csr=%h got=%h exp=%h", port_name(e.port),
                 cyc, rs1_addr_i, rs2_addr_i, csr_raddr_i, act, e.exp);
      else
        n_pass++;
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge with inputs already set: queue the reads
  // expected this cycle, take the edge, advance the model, then idle the enables.
  task automatic step();
    exp_q.push_back('{cyc, 0, (rs1_addr_i == 0) ? '0 : m_gpr[rs1_addr_i]});
    exp_q.push_back('{cyc, 1, (rs2_addr_i == 0) ? '0 : m_gpr[rs2_addr_i]});
    exp_q.push_back('{cyc, 2, model_csr_rd(int'(csr_raddr_i))});
    exp_q.push_back('{cyc, 3, m_csr['h305]});
    exp_q.push_back('{cyc, 4, m_csr['h341]});
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; wreg_i = 0; csr_wreg_i = 0; retire_i = 0; trap_i = 0;
  endtask

  task automatic gpr_wr(input logic [4:0] a, input logic [W-1:0] d);
    wreg_i = 1; rd_addr_i = a; rd_wdata_i = d;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [W-1:0] d);
    csr_wreg_i = 1; csr_waddr_i = a; csr_wdata_i = d;
  endtask

  logic [11:0] csr_tab [10] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'h001};

  initial begin
    rst = 1; wreg_i = 0; csr_wreg_i = 0; retire_i = 0; trap_i = 0;
    rs1_addr_i = 1; rs2_addr_i = 31; rd_addr_i = 0; rd_wdata_i = '0;
    csr_raddr_i = 12'hB00; csr_waddr_i = '0; csr_wdata_i = '0;
    trap_pc_i = '0; trap_cause_i = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset: two cycles in reset, then mcycle 0 -> 1 after release
    rst = 1; step();
    rst = 1; step();
    step();
    step();
    for (int i = 1; i < 32; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'(32 - i);
      csr_raddr_i = (i == 1) ? 12'h300 : 12'hF14;
      step();
    end

    // GPR write, no write-through, x0 discard
    gpr_wr(5, 64'hDEAD_BEEF_0000_0001); rs1_addr_i = 5; rs2_addr_i = 0; step();
    gpr_wr(0, 64'hFF);                   rs1_addr_i = 5; rs2_addr_i = 0; step();
    rs1_addr_i = 0; rs2_addr_i = 5; step();

    // Counter priority and wrap
    csr_raddr_i = 12'hB00; csr_wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE); step();
    step(); step(); step();
    csr_raddr_i = 12'hB02; retire_i = 1; step();
    csr_wr(12'hB02, 64'd10); retire_i = 1; step();
    step();

    // Trap beats software mepc write
    csr_raddr_i = 12'h341; csr_wr(12'h341, 64'h1234);
    trap_i = 1; trap_pc_i = 64'h8000_0013; trap_cause_i = 64'd2; step();
    step();
    csr_raddr_i = 12'h342; step();
    // Alternate run: trap alongside an mscratch write
    csr_raddr_i = 12'h340; csr_wr(12'h340, 64'hABCD_0000_5555);
    trap_i = 1; trap_pc_i = 64'h4000_0101; trap_cause_i = 64'd7; step();
    step();
    csr_raddr_i = 12'h341; step();
    csr_wr(12'h305, 64'h8000_0100); step();
    step();

    // Unimplemented and read-only CSRs
    csr_wr(12'h7C0, 64'd5); csr_raddr_i = 12'h7C0; step();
    csr_wr(12'hF14, 64'd7); step();
    csr_raddr_i = 12'hF14; step();

    // Mid-operation reset discards pending write and retire
    gpr_wr(3, 64'd1); retire_i = 1; step();
    rst = 1; gpr_wr(3, 64'd9); retire_i = 1; rs1_addr_i = 3; csr_raddr_i = 12'hB02; step();
    rs1_addr_i = 3; step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      wreg_i       = $urandom_range(0, 1);
      rd_addr_i    = 5'($urandom_range(0, 31));
      rd_wdata_i   = {$urandom, $urandom};
      rs1_addr_i   = ($urandom_range(0, 3) == 0) ? rd_addr_i : 5'($urandom_range(0, 31));
      rs2_addr_i   = 5'($urandom_range(0, 31));
      csr_wreg_i   = ($urandom_range(0, 2) == 0);
      csr_waddr_i  = csr_tab[$urandom_range(0, 9)];
      csr_wdata_i  = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      csr_raddr_i  = csr_tab[$urandom_range(0, 9)];
      retire_i     = $urandom_range(0, 1);
      trap_i       = ($urandom_range(0, 7) == 0);
      trap_pc_i    = {$urandom, $urandom};
      trap_cause_i = {$urandom, $urandom};
      step();
    end

    // Drain: every queued expectation must be consumed
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
